// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared fetch entry type for the fetch queue
//
// Purpose: defines fetch_entry_t, the fully decoded fetch entry carried from
// the fetch side to ID, plus its width and a helper for the sequential PC.
// Ports: none (package).

package ibex_pkg;

   typedef struct packed {
      logic [31:0] instr;
      logic [15:0] instr_c;
      logic [31:0] pc;
      logic        is_compressed;
      logic        illegal_c;
      logic        err;
      logic        err_plus2;
      logic        bp_taken;
      logic        dummy;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

   // A compressed entry that faulted is treated as a full-width fetch slot,
   // so only a clean compressed entry advances the PC by 2.
   function automatic logic [31:0] fetch_next_pc(input fetch_entry_t e);
      return e.pc + ((e.is_compressed & ~e.err) ? 32'd2 : 32'd4);
   endfunction

endpackage

// File: rtl/ibex_fetch_queue_pc_check.sv
// rtl/ibex_fetch_queue_pc_check.sv - sequential-PC integrity check on the queue head
//
// Purpose: remembers the PC that should follow the last popped entry and
// flags a head entry whose PC breaks the sequence. Only instantiated when
// IBEX_FETCH_QUEUE_PC_CHECK_EN is defined.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         PC redirect; the sequence is no longer known
//   pop_i           head entry is consumed this cycle (flush already excluded)
//   out_valid_i     head entry is valid
//   head_i          current head entry (also the popped entry on pop_i)
//   alert_o         head PC differs from the expected sequential PC

module ibex_fetch_queue_pc_check
   import ibex_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         pop_i,
   input  logic         out_valid_i,
   input  fetch_entry_t head_i,
   output logic         alert_o
);

   logic [31:0] expected_pc_q;
   logic        seq_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         expected_pc_q <= '0;
         seq_q         <= 1'b0;
      end else if (flush_i) begin
         seq_q <= 1'b0;
      end else if (pop_i) begin
         expected_pc_q <= fetch_next_pc(head_i);
         // A predicted-taken entry ends the sequential run; a dummy entry
         // neither starts nor ends one.
         if (head_i.bp_taken) begin
            seq_q <= 1'b0;
         end else if (!head_i.dummy) begin
            seq_q <= 1'b1;
         end
      end
   end

   assign alert_o = out_valid_i & seq_q & ~head_i.dummy & (head_i.pc != expected_pc_q);

endmodule

// File: rtl/ibex_fetch_queue.sv
// rtl/ibex_fetch_queue.sv - Depth-entry FIFO of decoded fetch entries between IF and ID
//
// Purpose: circular buffer with valid/ready on both sides, single-cycle
// flush, optional fall-through when empty, optional sequential-PC check
// (enabled by defining IBEX_FETCH_QUEUE_PC_CHECK_EN).
// Parameters:
//   Depth        number of entries (>= 1)
//   FallThrough  empty queue presents in_entry_i combinationally
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                PC redirect, discards all entries
//   in_valid_i/in_ready_o  fetch-side handshake, in_entry_i entry
//   out_valid_o/out_ready_i ID-side handshake, out_entry_o head entry
//   out_new_o              high the cycle after a pop
//   count_o                occupancy
//   pc_mismatch_alert_o    sequential-PC violation (0 when check disabled)

module ibex_fetch_queue
   import ibex_pkg::*;
#(
   parameter int unsigned Depth       = 2,
   parameter bit          FallThrough = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  fetch_entry_t               in_entry_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output fetch_entry_t               out_entry_o,
   output logic                       out_new_o,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output logic                       pc_mismatch_alert_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   fetch_entry_t    mem_q [Depth];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;
   logic            out_new_q;

   logic empty, full, fall_through;
   logic push, pop, bypass, wr_en, rd_en;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == DepthCnt);

   // Ready depends on occupancy only: no path from out_ready_i.
   assign in_ready_o = ~full;

   assign fall_through = FallThrough & empty & in_valid_i & ~flush_i;

   assign out_valid_o = ~empty | fall_through;
   assign out_entry_o = fall_through ? in_entry_i : mem_q[rptr_q];

   assign push = in_valid_i & in_ready_o & ~flush_i;
   assign pop  = out_valid_o & out_ready_i & ~flush_i;

   // An entry that falls through and is consumed at once never touches storage.
   assign bypass = fall_through & pop;
   assign wr_en  = push & ~bypass;
   assign rd_en  = pop & ~bypass;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         out_new_q <= 1'b0;
      end else begin
         out_new_q <= pop;
         if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
         end else begin
            if (wr_en) begin
               wptr_q <= ptr_inc(wptr_q);
            end
            if (rd_en) begin
               rptr_q <= ptr_inc(rptr_q);
            end
            if (wr_en & ~rd_en) begin
               count_q <= count_q + 1'b1;
            end else if (rd_en & ~wr_en) begin
               count_q <= count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wptr_q] <= in_entry_i;
      end
   end

   assign out_new_o = out_new_q;
   assign count_o   = count_q;

`ifdef IBEX_FETCH_QUEUE_PC_CHECK_EN
   ibex_fetch_queue_pc_check u_pc_check (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .pop_i       (pop),
      .out_valid_i (out_valid_o),
      .head_i      (out_entry_o),
      .alert_o     (pc_mismatch_alert_o)
   );
`else
   assign pc_mismatch_alert_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_fetch_queue.sv
// tb/tb_ibex_fetch_queue.sv - self-checking bench for ibex_fetch_queue

module tb_ibex_fetch_queue;
   import ibex_pkg::*;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic         flush = 1'b0;
   logic         iv = 1'b0;
   logic         ordy = 1'b0;
   fetch_entry_t ient = '0;

   logic         ir [3];
   logic         ov [3];
   fetch_entry_t oe [3];
   logic         on [3];
   logic [1:0]   cnt [3];
   logic         al [3];

   int tot = 0;
   int bad = 0;

   // Reference model: one queue per instance.
   int           depth_m [3] = '{2, 3, 2};
   bit           ft_m [3]    = '{1'b0, 1'b0, 1'b1};
   fetch_entry_t mq [3][$];
   bit           mnew [3];
   logic [31:0]  mexp_pc [3];
   bit           mseq [3];

   always #5 clk = ~clk;

   ibex_fetch_queue #(.Depth(2), .FallThrough(1'b0)) u_d2 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .in_valid_i(iv), .in_ready_o(ir[0]), .in_entry_i(ient),
      .out_valid_o(ov[0]), .out_ready_i(ordy), .out_entry_o(oe[0]),
      .out_new_o(on[0]), .count_o(cnt[0]), .pc_mismatch_alert_o(al[0]));

   ibex_fetch_queue #(.Depth(3), .FallThrough(1'b0)) u_d3 (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .in_valid_i(iv), .in_ready_o(ir[1]), .in_entry_i(ient),
      .out_valid_o(ov[1]), .out_ready_i(ordy), .out_entry_o(oe[1]),
      .out_new_o(on[1]), .count_o(cnt[1]), .pc_mismatch_alert_o(al[1]));

   ibex_fetch_queue #(.Depth(2), .FallThrough(1'b1)) u_ft (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .in_valid_i(iv), .in_ready_o(ir[2]), .in_entry_i(ient),
      .out_valid_o(ov[2]), .out_ready_i(ordy), .out_entry_o(oe[2]),
      .out_new_o(on[2]), .count_o(cnt[2]), .pc_mismatch_alert_o(al[2]));

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tot++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic fetch_entry_t mk(input logic [31:0] pc, input bit comp, input bit err);
      fetch_entry_t e;
      e               = '0;
      e.instr         = $urandom;
      e.instr_c       = 16'($urandom);
      e.pc            = pc;
      e.is_compressed = comp;
      e.err           = err;
      return e;
   endfunction

   function automatic fetch_entry_t rand_entry(input logic [31:0] pc);
      fetch_entry_t e;
      e           = mk(pc, 1'($urandom), ($urandom_range(0, 7) == 0));
      e.illegal_c = 1'($urandom);
      e.err_plus2 = 1'($urandom);
      e.bp_taken  = ($urandom_range(0, 9) == 0);
      e.dummy     = ($urandom_range(0, 9) == 0);
      return e;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 3; k++) begin
         mq[k].delete();
         mnew[k]    = 1'b0;
         mexp_pc[k] = '0;
         mseq[k]    = 1'b0;
      end
   endfunction

   // One clock cycle: drive, compare every instance against the model, advance.
   task automatic step(input bit v, input fetch_entry_t e, input bit r, input bit f);
      bit           eov [3];
      fetch_entry_t eent [3];
      bit           epush [3];
      bit           epop [3];
      bit           ebyp [3];
      iv = v; ient = e; ordy = r; flush = f;
      #2;
      for (int k = 0; k < 3; k++) begin
         bit eal;
         int n;
         n        = mq[k].size();
         eov[k]   = (n != 0) || (ft_m[k] && v && !f);
         eent[k]  = (n != 0) ? mq[k][0] : e;
         epush[k] = v && (n != depth_m[k]) && !f;
         epop[k]  = eov[k] && r && !f;
         ebyp[k]  = (n == 0) && epop[k];
`ifdef IBEX_FETCH_QUEUE_PC_CHECK_EN
         eal = eov[k] && mseq[k] && !eent[k].dummy && (eent[k].pc != mexp_pc[k]);
`else
         eal = 1'b0;
`endif
         check_val($sformatf("i%0d_in_ready", k), ir[k], (n != depth_m[k]));
         check_val($sformatf("i%0d_out_valid", k), ov[k], eov[k]);
         check_val($sformatf("i%0d_count", k), cnt[k], n);
         check_val($sformatf("i%0d_out_new", k), on[k], mnew[k]);
         check_val($sformatf("i%0d_alert", k), al[k], eal);
         if (eov[k]) check_val($sformatf("i%0d_out_entry", k), oe[k], eent[k]);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         mnew[k] = epop[k];
         if (f) begin
            mq[k].delete();
            mseq[k] = 1'b0;
         end else begin
            if (!ebyp[k]) begin
               if (epop[k]) void'(mq[k].pop_front());
               if (epush[k]) mq[k].push_back(e);
            end
            if (epop[k]) begin
               mexp_pc[k] = eent[k].pc + ((eent[k].is_compressed && !eent[k].err) ? 32'd2 : 32'd4);
               if (eent[k].bp_taken) mseq[k] = 1'b0;
               else if (!eent[k].dummy) mseq[k] = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("%s_i%0d_in_ready", tag, k), ir[k], 1'b1);
         check_val($sformatf("%s_i%0d_out_valid", tag, k), ov[k], 1'b0);
         check_val($sformatf("%s_i%0d_count", tag, k), cnt[k], 2'd0);
         check_val($sformatf("%s_i%0d_out_new", tag, k), on[k], 1'b0);
         check_val($sformatf("%s_i%0d_alert", tag, k), al[k], 1'b0);
         check_val($sformatf("%s_i%0d_out_entry", tag, k), oe[k], '0);
      end
   endtask

   initial begin
      fetch_entry_t z;
      logic [31:0]  pc;
      z = '0;
      model_clear();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Fill: three offers with ID stalled; third is held off on Depth=2.
      step(1'b1, mk(32'h80, 1'b0, 1'b0), 1'b0, 1'b0);
      step(1'b1, mk(32'h84, 1'b0, 1'b0), 1'b0, 1'b0);
      iv = 1'b1; ient = mk(32'h88, 1'b0, 1'b0); ordy = 1'b0; flush = 1'b0;
      #1;
      check_val("fill_count", cnt[0], 2'd2);
      check_val("fill_held_off", ir[0], 1'b0);
      step(1'b1, ient, 1'b0, 1'b0);
      iv = 1'b0; ordy = 1'b1;
      #1;
      check_val("fill_head_pc", oe[0].pc, 32'h80);
      repeat (4) step(1'b0, z, 1'b1, 1'b0);

      // Continuous push/pop of 10 entries: Depth=3 pointers wrap.
      for (int i = 0; i < 10; i++) step(1'b1, mk(32'h1000 + 4 * i, 1'b0, 1'b0), 1'b1, 1'b0);
      repeat (4) step(1'b0, z, 1'b1, 1'b0);

      // Flush with two entries queued and a simultaneous push.
      step(1'b1, mk(32'h40, 1'b0, 1'b0), 1'b0, 1'b0);
      step(1'b1, mk(32'h44, 1'b0, 1'b0), 1'b0, 1'b0);
      step(1'b1, mk(32'h48, 1'b0, 1'b0), 1'b0, 1'b1);
      iv = 1'b0; ordy = 1'b1; flush = 1'b0;
      #1;
      check_val("flush_count", cnt[0], 2'd0);
      check_val("flush_valid", ov[0], 1'b0);
      repeat (2) step(1'b0, z, 1'b1, 1'b0);

      // Fall-through into an empty queue.
      iv = 1'b1; ient = mk(32'h100, 1'b0, 1'b0); ordy = 1'b1;
      #1;
      check_val("ft_valid", ov[2], 1'b1);
      check_val("ft_pc", oe[2].pc, 32'h100);
      step(1'b1, ient, 1'b1, 1'b0);
      check_val("ft_count", cnt[2], 2'd0);
      check_val("ft_out_new", on[2], 1'b1);
      repeat (3) step(1'b0, z, 1'b1, 1'b0);

`ifdef IBEX_FETCH_QUEUE_PC_CHECK_EN
      step(1'b0, z, 1'b0, 1'b1);
      step(1'b1, mk(32'h200, 1'b1, 1'b0), 1'b1, 1'b0);
      iv = 1'b1; ordy = 1'b0; ient = mk(32'h202, 1'b0, 1'b0);
      #1;
      check_val("pc_seq_ok", al[2], 1'b0);
      ient = mk(32'h206, 1'b0, 1'b0);
      #1;
      check_val("pc_seq_bad", al[2], 1'b1);
      step(1'b0, z, 1'b0, 1'b1);
      step(1'b1, mk(32'h300, 1'b1, 1'b1), 1'b1, 1'b0);
      iv = 1'b1; ordy = 1'b0; ient = mk(32'h304, 1'b0, 1'b0);
      #1;
      check_val("pc_err_comp", al[2], 1'b0);
      step(1'b0, z, 1'b0, 1'b1);
      iv = 1'b1; ordy = 1'b0; ient = mk(32'h999, 1'b0, 1'b0);
      #1;
      check_val("pc_after_flush", al[2], 1'b0);
      step(1'b0, z, 1'b0, 1'b1);
`endif

      // Randomized traffic, mostly sequential PCs.
      pc = 32'h2000;
      for (int i = 0; i < 600; i++) begin
         fetch_entry_t e;
         bit v;
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) pc = $urandom & 32'hffff_fffe;
         e = rand_entry(pc);
         if (v) pc = pc + 32'd2 * 32'($urandom_range(1, 2));
         step(v, e, ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end

      // Asynchronous reset mid-stream with two entries queued.
      step(1'b0, z, 1'b0, 1'b1);
      step(1'b1, mk(32'h500, 1'b0, 1'b0), 1'b0, 1'b0);
      step(1'b1, mk(32'h504, 1'b0, 1'b0), 1'b0, 1'b0);
      iv = 1'b0; ordy = 1'b0; flush = 1'b0;
      #1;
      check_val("areset_pre_count", cnt[0], 2'd2);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("areset");
      model_clear();
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) step(1'b1, mk(32'h600 + 4 * i, 1'b0, 1'b0), 1'($urandom), 1'b0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
